stream_dwc_downsize: RTL and testbench



---
 rtl/stream_dwc_downsize.sv | 151 +++++++++++++++
 tb/tb_stream_dwc_downsize.sv | 179 +++++++++++++++++
 2 files changed

// File: rtl/stream_dwc_downsize.sv
// ---------------------------------------------------------------------------
// stream_dwc_downsize
//   AXI-Stream width down-converter. Each accepted IN_WIDTH word is emitted
//   as RATIO = IN_WIDTH/OUT_WIDTH narrow beats, least-significant slice first.
//   A single holding register gives one output beat per cycle. When the last
//   slice leaves, the next input word can be loaded in the same cycle, so a
//   continuous stream has no bubble between words.
//
// Parameters
//   IN_WIDTH   wide input width in bits (default 256)
//   OUT_WIDTH  narrow output width in bits (default 64); IN_WIDTH must be an
//              exact multiple of OUT_WIDTH
//
// Ports
//   ap_clk            clock; all state changes on the rising edge
//   ap_rst_n          asynchronous active-low reset
//   in0_V_V_TDATA     wide input word
//   in0_V_V_TVALID    input valid
//   in0_V_V_TREADY    input ready
//   out_V_V_TDATA     narrow output beat
//   out_V_V_TVALID    output valid
//   out_V_V_TREADY    output ready
//   beat_count        (only with STREAM_DWC_BEATCNT_EN) free-running count of
//                     output handshakes, modulo 2^32
//
// Optional feature macro: STREAM_DWC_BEATCNT_EN
// ---------------------------------------------------------------------------
module stream_dwc_downsize #(
   parameter int IN_WIDTH  = 256,
   parameter int OUT_WIDTH = 64
) (
   input  logic                 ap_clk,
   input  logic                 ap_rst_n,
   input  logic [IN_WIDTH-1:0]  in0_V_V_TDATA,
   input  logic                 in0_V_V_TVALID,
   output logic                 in0_V_V_TREADY,
   output logic [OUT_WIDTH-1:0] out_V_V_TDATA,
   output logic                 out_V_V_TVALID,
   input  logic                 out_V_V_TREADY
`ifdef STREAM_DWC_BEATCNT_EN
   ,
   output logic [31:0]          beat_count
`endif
);

   localparam int RATIO = IN_WIDTH / OUT_WIDTH;
   localparam int CW    = (RATIO > 1) ? $clog2(RATIO) : 1;

   if ((IN_WIDTH % OUT_WIDTH) != 0) begin : g_bad_ratio
      $error("stream_dwc_downsize: IN_WIDTH must be an integer multiple of OUT_WIDTH");
   end

   // EMIT means the holding register is occupied (full).
   typedef enum logic {
      EMPTY = 1'b0,
      EMIT  = 1'b1
   } state_t;

   state_t                state_q;
   logic [IN_WIDTH-1:0]   data_q;
   logic [CW-1:0]         idx_q;
   logic                  en_q;

   logic                  full_s;
   logic                  last_s;
   logic                  in_fire_s;
   logic                  out_fire_s;
   logic [CW-1:0]         idx_d;
   logic [OUT_WIDTH-1:0]  out_data_s;

   assign full_s     = (state_q == EMIT);
   assign last_s     = (idx_q == CW'(RATIO - 1));
   assign idx_d      = idx_q + CW'(1);

   // Ready passes the downstream ready through only on the last slice, which
   // lets a new word replace the old one in the cycle its final beat leaves.
   assign in0_V_V_TREADY = en_q & (~full_s | (last_s & out_V_V_TREADY));
   assign out_V_V_TVALID = full_s;
   assign out_V_V_TDATA  = out_data_s;

   assign in_fire_s  = in0_V_V_TVALID & in0_V_V_TREADY;
   assign out_fire_s = full_s & out_V_V_TREADY;

   // Select the active slice of the holding register.
   always_comb begin
      out_data_s = {OUT_WIDTH{1'b0}};
      for (int k = 0; k < RATIO; k++) begin
         if (idx_q == CW'(k)) begin
            out_data_s = data_q[k*OUT_WIDTH +: OUT_WIDTH];
         end else begin
            out_data_s = out_data_s;
         end
      end
   end

   // Holding-register FSM: load, step through the slices, reload or drain.
   always_ff @(posedge ap_clk or negedge ap_rst_n) begin
      if (!ap_rst_n) begin
         state_q <= EMPTY;
         data_q  <= {IN_WIDTH{1'b0}};
         idx_q   <= {CW{1'b0}};
         en_q    <= 1'b0;
      end else begin
         en_q <= 1'b1;
         case (state_q)
            EMPTY: begin
               if (in_fire_s) begin
                  data_q  <= in0_V_V_TDATA;
                  idx_q   <= {CW{1'b0}};
                  state_q <= EMIT;
               end
            end
            EMIT: begin
               if (out_fire_s) begin
                  if (!last_s) begin
                     idx_q <= idx_d;
                  end else if (in_fire_s) begin
                     data_q <= in0_V_V_TDATA;
                     idx_q  <= {CW{1'b0}};
                  end else begin
                     idx_q   <= {CW{1'b0}};
                     state_q <= EMPTY;
                  end
               end
            end
            default: begin
               state_q <= EMPTY;
               idx_q   <= {CW{1'b0}};
            end
         endcase
      end
   end

`ifdef STREAM_DWC_BEATCNT_EN
   logic [31:0] beat_cnt_q;

   // Count output handshakes; wraps naturally at 2^32.
   always_ff @(posedge ap_clk or negedge ap_rst_n) begin
      if (!ap_rst_n) begin
         beat_cnt_q <= 32'd0;
      end else if (out_fire_s) begin
         beat_cnt_q <= beat_cnt_q + 32'd1;
      end else begin
         beat_cnt_q <= beat_cnt_q;
      end
   end

   assign beat_count = beat_cnt_q;
`endif

endmodule

// File: tb/tb_stream_dwc_downsize.sv
module tb_stream_dwc_downsize;

   localparam int IN_W  = 256;
   localparam int OUT_W = 64;
   localparam int R     = IN_W / OUT_W;

   logic             clk = 1'b0;
   logic             rst_n;
   logic [IN_W-1:0]  in_dat;
   logic             in_vld;
   logic             in_rdy;
   logic [OUT_W-1:0] out_dat;
   logic             out_vld;
   logic             out_rdy;
`ifdef STREAM_DWC_BEATCNT_EN
   logic [31:0]      beat_count;
`endif

   always #5 clk = ~clk;

   stream_dwc_downsize #(.IN_WIDTH(IN_W), .OUT_WIDTH(OUT_W)) dut (
      .ap_clk         (clk),
      .ap_rst_n       (rst_n),
      .in0_V_V_TDATA  (in_dat),
      .in0_V_V_TVALID (in_vld),
      .in0_V_V_TREADY (in_rdy),
      .out_V_V_TDATA  (out_dat),
      .out_V_V_TVALID (out_vld),
      .out_V_V_TREADY (out_rdy)
`ifdef STREAM_DWC_BEATCNT_EN
      ,
      .beat_count     (beat_count)
`endif
   );

   // Reference model: beats still owed from the word in the holding register,
   // whether the converter has come out of reset, and an output-beat count.
   logic [OUT_W-1:0] pend[$];
   bit               en_m;
   logic [31:0]      cnt_m;
   int               beats_seen;

   int n_cmp  = 0;
   int n_fail = 0;

   task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
      n_cmp++;
      assert (obs === exp) else begin
         n_fail++;
         $error("FAIL %s: observed %h expected %h", tag, obs, exp);
      end
   endtask

   function automatic logic [IN_W-1:0] rand_word();
      logic [IN_W-1:0] w;
      for (int i = 0; i < IN_W / 32; i++) w[i*32 +: 32] = $urandom;
      return w;
   endfunction

   // One clock cycle: drive inputs, check outputs against the model, then
   // advance the model by whatever handshakes the model says occur.
   task automatic step(input logic iv, input logic [IN_W-1:0] d, input logic ordy,
                       output logic acc);
      logic exp_rdy, in_f, out_f;
      in_vld  = iv;
      in_dat  = d;
      out_rdy = ordy;
      #1;
      exp_rdy = en_m && (pend.size() == 0 || (pend.size() == 1 && ordy));
      chk("tready", {63'd0, in_rdy}, {63'd0, exp_rdy});
      chk("tvalid", {63'd0, out_vld}, {63'd0, pend.size() != 0});
      if (pend.size() != 0) chk("tdata", out_dat, pend[0]);
`ifdef STREAM_DWC_BEATCNT_EN
      chk("beat_count", {32'd0, beat_count}, {32'd0, cnt_m});
`endif
      in_f  = iv && exp_rdy;
      out_f = (pend.size() != 0) && ordy;
      @(posedge clk);
      if (out_f) begin
         void'(pend.pop_front());
         cnt_m = cnt_m + 32'd1;
         beats_seen++;
      end
      if (in_f) for (int k = 0; k < R; k++) pend.push_back(d[k*OUT_W +: OUT_W]);
      if (rst_n) en_m = 1'b1;
      acc = in_f;
      #1;
   endtask

   initial begin
      logic            acc;
      logic [IN_W-1:0] w;
      logic [IN_W-1:0] words [8];
      int              wi;
      bit              offer;

      rst_n = 1'b0; in_vld = 1'b0; in_dat = '0; out_rdy = 1'b0;
      en_m = 1'b0; cnt_m = 32'd0; beats_seen = 0;

      // Reset held: both valid and ready low.
      @(posedge clk); @(posedge clk); #1;
      chk("rst_tready", {63'd0, in_rdy}, 64'd0);
      chk("rst_tvalid", {63'd0, out_vld}, 64'd0);
      rst_n = 1'b1;
      // First cycle after release: still not ready; next cycle ready.
      step(1'b0, '0, 1'b1, acc);
      step(1'b0, '0, 1'b1, acc);

      // Single word, slice k holds k+1.
      w = {64'd4, 64'd3, 64'd2, 64'd1};
      step(1'b1, w, 1'b1, acc);
      chk("single_acc", {63'd0, acc}, 64'd1);
      for (int i = 0; i < R + 1; i++) step(1'b0, '0, 1'b1, acc);

      // Eight back-to-back words with both sides always ready.
      for (int i = 0; i < 8; i++) words[i] = rand_word();
      wi = 0; beats_seen = 0;
      for (int c = 0; c < 8 * R + 1; c++) begin
         step(wi < 8, words[(wi < 8) ? wi : 0], 1'b1, acc);
         if (acc) wi++;
      end
      chk("b2b_words", 64'(wi), 64'd8);
      chk("b2b_beats", 64'(beats_seen), 64'(8 * R));
      step(1'b0, '0, 1'b1, acc);

      // Downstream stall for 5 cycles with beat 2 presented; an input word is
      // offered throughout and must be held off until the last slice.
      step(1'b1, rand_word(), 1'b1, acc);
      step(1'b0, '0, 1'b1, acc);
      w = rand_word();
      for (int i = 0; i < 5; i++) step(1'b1, w, 1'b0, acc);
      offer = 1'b1;
      for (int i = 0; i < 2 * R + 1; i++) begin
         step(offer, w, 1'b1, acc);
         if (acc) offer = 1'b0;
      end
      chk("stall_drained", 64'(pend.size()), 64'd0);

      // Reset after the first beat of a word; the remnant must vanish.
      step(1'b1, rand_word(), 1'b1, acc);
      step(1'b0, '0, 1'b1, acc);
      rst_n = 1'b0;
      #1;
      chk("midrst_tvalid", {63'd0, out_vld}, 64'd0);
      chk("midrst_tready", {63'd0, in_rdy}, 64'd0);
      pend.delete(); en_m = 1'b0; cnt_m = 32'd0;
      @(posedge clk); #1;
      rst_n = 1'b1;
      step(1'b0, '0, 1'b1, acc);
      w = rand_word();
      step(1'b1, w, 1'b1, acc);
      #0;
      chk("after_rst_b0", {63'd0, out_vld}, 64'd1);
      chk("after_rst_b0_data", out_dat, w[OUT_W-1:0]);
      for (int i = 0; i < R + 1; i++) step(1'b0, '0, 1'b1, acc);

      // Randomized traffic on both sides.
      for (int i = 0; i < 400; i++)
         step($urandom_range(0, 1) == 1, rand_word(), $urandom_range(0, 3) != 0, acc);
      for (int i = 0; i < R + 1; i++) step(1'b0, '0, 1'b1, acc);
      chk("rand_drained", 64'(pend.size()), 64'd0);

`ifdef STREAM_DWC_BEATCNT_EN
      // Counter wrap: preload near the top and push three beats through.
      force dut.beat_cnt_q = 32'hFFFF_FFFE;
      #1;
      release dut.beat_cnt_q;
      cnt_m = 32'hFFFF_FFFE;
      step(1'b1, rand_word(), 1'b1, acc);
      for (int i = 0; i < 3; i++) step(1'b0, '0, 1'b1, acc);
      chk("cnt_wrap", {32'd0, beat_count}, 64'd1);
      for (int i = 0; i < R; i++) step(1'b0, '0, 1'b1, acc);
`endif

      $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
      $finish;
   end

endmodule
